// File: rtl/riscv_exu_wb_arb_if.sv
// Write-back arbitration bundle: functional-unit requests in, register-file
// write/unlock port and status out.
interface riscv_exu_wb_arb_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ-1:0][4:0]   req_rd;
  logic [N_REQ-1:0][31:0]  req_data;
  logic [N_REQ-1:0]        req_rdy;
  logic                    wb_stall;
  logic                    register_write_en;
  logic [4:0]              register_write;
  logic [31:0]             register_write_data;
  logic                    register_unlock_en;
  logic [4:0]              register_unlock;
  logic [IDX_W-1:0]        grant_id;
  logic                    busy;

  modport slave (
    input  req_vld, req_rd, req_data, wb_stall,
    output req_rdy, register_write_en, register_write, register_write_data,
           register_unlock_en, register_unlock, grant_id, busy
  );

  modport master (
    output req_vld, req_rd, req_data, wb_stall,
    input  req_rdy, register_write_en, register_write, register_write_data,
           register_unlock_en, register_unlock, grant_id, busy
  );
endinterface

// File: rtl/riscv_exu_wb_arb.sv
// Round-robin write-back arbiter: N_REQ functional units share one registered
// register-file write port; every grant also releases the destination lock.
module riscv_exu_wb_arb #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                clock,
  input  logic                reset,
  riscv_exu_wb_arb_if.slave   wb
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  int unsigned      cand;

  logic             wen_q, uen_q;
  logic [4:0]       wa_q, ua_q;
  logic [31:0]      wd_q;
  logic [IDX_W-1:0] gid_q;

  // Search starts at rr_ptr and wraps modulo N_REQ, so the pointer stays in range
  // even when N_REQ is not a power of two.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % N_REQ;
      if (!gnt_vld && wb.req_vld[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
    if (wb.wb_stall || reset) gnt_vld = 1'b0;
  end

  always_comb begin
    wb.req_rdy = '0;
    if (gnt_vld) wb.req_rdy[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) rr_ptr_d = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      wen_q    <= 1'b0;
      uen_q    <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      ua_q     <= '0;
      gid_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wen_q    <= gnt_vld && (wb.req_rd[gnt_idx] != 5'd0);
      uen_q    <= gnt_vld;
      if (gnt_vld) begin
        wa_q  <= wb.req_rd[gnt_idx];
        wd_q  <= wb.req_data[gnt_idx];
        ua_q  <= wb.req_rd[gnt_idx];
        gid_q <= gnt_idx;
      end
    end
  end

  assign wb.register_write_en   = wen_q;
  assign wb.register_write      = wa_q;
  assign wb.register_write_data = wd_q;
  assign wb.register_unlock_en  = uen_q;
  assign wb.register_unlock     = ua_q;
  assign wb.grant_id            = gid_q;
  assign wb.busy                = |wb.req_vld;

endmodule

// File: tb/tb_riscv_exu_wb_arb.sv
// Bench for riscv_exu_wb_arb (N_REQ=3): vector table with a write-back
// scoreboard, plus a randomized-stall fairness sequence.
module tb_riscv_exu_wb_arb;
  localparam int unsigned N = 3;
  localparam int unsigned IW = $clog2(N);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_exu_wb_arb_if #(.N_REQ(N), .IDX_W(IW)) intf ();
  riscv_exu_wb_arb #(.N_REQ(N), .IDX_W(IW)) dut (
    .clock (clk),
    .reset (reset),
    .wb    (intf.slave)
  );

  typedef struct {
    bit               rst;
    bit               stall;
    logic [2:0]       vld;
    logic [2:0][4:0]  rd;
    logic [2:0][31:0] data;
    logic [2:0]       exp_rdy;
  } vec_t;

  typedef struct {
    bit          is_rst;
    logic        uen;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [IW-1:0] gid;
    bit          chk_wr;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sbq[$];
  int    checks = 0;
  int    errors = 0;
  logic [31:0] rf [32];
  logic [4:0]  hrd;
  logic [31:0] hdata;
  logic [IW-1:0] hgid;
  bit          hknown;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit r, bit s, logic [2:0] v,
                              logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                              logic [2:0] rdy);
    vec_t x;
    x.rst = r; x.stall = s; x.vld = v;
    x.rd[0] = a0; x.rd[1] = a1; x.rd[2] = a2;
    x.data[0] = d0; x.data[1] = d1; x.data[2] = d2;
    x.exp_rdy = rdy;
    return x;
  endfunction

  task automatic step(input vec_t v, input int n);
    exp_t e;
    int   g;
    reset         = v.rst;
    intf.wb_stall = v.stall;
    intf.req_vld  = v.vld;
    intf.req_rd   = v.rd;
    intf.req_data = v.data;
    #1;
    chk($sformatf("rdy[%0d]", n), 32'(intf.req_rdy), 32'(v.exp_rdy));
    chk($sformatf("busy[%0d]", n), 32'(intf.busy), 32'(|v.vld));
    e = '{default: '0};
    if (v.rst) begin
      e.is_rst = 1'b1; e.chk_wr = 1'b1;
      hrd = '0; hdata = '0; hgid = '0; hknown = 1'b1;
    end else if (v.exp_rdy != 3'b000) begin
      g = (v.exp_rdy == 3'b001) ? 0 : (v.exp_rdy == 3'b010) ? 1 : 2;
      e.uen = 1'b1; e.wen = (v.rd[g] != 5'd0);
      e.rd = v.rd[g]; e.data = v.data[g]; e.gid = IW'(g);
      e.chk_wr = e.wen;
      hgid = IW'(g);
      if (e.wen) begin hrd = v.rd[g]; hdata = v.data[g]; hknown = 1'b1; end
      else hknown = 1'b0;
    end else begin
      e.rd = hrd; e.data = hdata; e.gid = hgid; e.chk_wr = hknown;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk($sformatf("wen[%0d]", n), 32'(intf.register_write_en), 32'(e.wen));
    chk($sformatf("uen[%0d]", n), 32'(intf.register_unlock_en), 32'(e.uen));
    chk($sformatf("gid[%0d]", n), 32'(intf.grant_id), 32'(e.gid));
    if (e.uen || e.is_rst)
      chk($sformatf("unlock[%0d]", n), 32'(intf.register_unlock), 32'(e.rd));
    if (e.chk_wr) begin
      chk($sformatf("wa[%0d]", n), 32'(intf.register_write), 32'(e.rd));
      chk($sformatf("wd[%0d]", n), intf.register_write_data, e.data);
    end
    if (intf.register_write_en === 1'b1) rf[intf.register_write] = intf.register_write_data;
  endtask

  initial begin
    int last [N];
    int gc;
    int g;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b1; intf.wb_stall = 1'b0; intf.req_vld = '0;
    intf.req_rd = '0; intf.req_data = '0;
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back(mk(1,0,3'b000, 0,0,0, 0,0,0, 3'b000));
    // single request from unit 1
    tbl.push_back(mk(0,0,3'b010, 0,5,0, 0,32'hDEADBEEF,0, 3'b010));
    tbl.push_back(mk(0,0,3'b000, 0,0,0, 0,0,0, 3'b000));
    // round robin from reset
    tbl.push_back(mk(1,0,3'b111, 1,2,3, 32'h10,32'h20,32'h30, 3'b000));
    tbl.push_back(mk(0,0,3'b111, 1,2,3, 32'h10,32'h20,32'h30, 3'b001));
    tbl.push_back(mk(0,0,3'b111, 1,2,3, 32'h11,32'h20,32'h30, 3'b010));
    tbl.push_back(mk(0,0,3'b111, 1,2,3, 32'h11,32'h21,32'h30, 3'b100));
    tbl.push_back(mk(0,0,3'b111, 1,2,3, 32'h11,32'h21,32'h31, 3'b001));
    tbl.push_back(mk(0,0,3'b111, 1,2,3, 32'h12,32'h21,32'h31, 3'b010));
    tbl.push_back(mk(0,0,3'b111, 1,2,3, 32'h12,32'h22,32'h31, 3'b100));
    // x0 write-back: unlock only
    tbl.push_back(mk(0,0,3'b001, 0,0,0, 32'h1234,0,0, 3'b001));
    // stall holds pointer at 1
    tbl.push_back(mk(0,1,3'b111, 1,2,3, 32'h13,32'h23,32'h33, 3'b000));
    tbl.push_back(mk(0,1,3'b111, 1,2,3, 32'h13,32'h23,32'h33, 3'b000));
    tbl.push_back(mk(0,1,3'b111, 1,2,3, 32'h13,32'h23,32'h33, 3'b000));
    tbl.push_back(mk(0,0,3'b111, 1,2,3, 32'h13,32'h23,32'h33, 3'b010));
    // same rd collision with pointer at 2
    tbl.push_back(mk(0,0,3'b101, 7,0,7, 32'hA,0,32'hB, 3'b100));
    tbl.push_back(mk(0,0,3'b001, 7,0,0, 32'hA,0,0, 3'b001));
    // reset mid-stream
    tbl.push_back(mk(0,0,3'b010, 0,9,0, 0,32'h99,0, 3'b010));
    tbl.push_back(mk(1,0,3'b110, 0,4,6, 0,32'h41,32'h61, 3'b000));
    tbl.push_back(mk(0,0,3'b110, 0,4,6, 0,32'h41,32'h61, 3'b010));
    tbl.push_back(mk(0,0,3'b100, 0,0,6, 0,0,32'h61, 3'b100));
    tbl.push_back(mk(0,0,3'b000, 0,0,0, 0,0,0, 3'b000));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
    chk("rf7_final", rf[7], 32'hA);

    // fairness under random stalls with all units continuously valid
    for (int i = 0; i < N; i++) last[i] = -1;
    gc = 0;
    reset = 1'b0; intf.req_vld = 3'b111;
    for (int c = 0; c < 24; c++) begin
      intf.wb_stall = ($urandom_range(0, 3) == 0);
      #1;
      if (intf.wb_stall) chk("stall_rdy", 32'(intf.req_rdy), 32'h0);
      else begin
        chk("onehot", 32'($countones(intf.req_rdy)), 32'd1);
        g = (intf.req_rdy[0]) ? 0 : (intf.req_rdy[1]) ? 1 : 2;
        if (last[g] >= 0) chk("fair_gap", 32'(gc - last[g]), 32'(N));
        last[g] = gc;
        gc++;
      end
      @(posedge clk);
      #1;
    end
    intf.req_vld = '0; intf.wb_stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
